memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//   MEM stage of the 5-stage MIPS pipeline, directly downstream of Execute.
//   Holds the EX/MEM pipeline register, resolves the branch (PCSrc), performs
//   the data-memory word load/store, and drives the MEM/WB register that
//   feeds Writeback.
// PARAMETERS
//   DEPTH   256  data-memory size in 32-bit words (power of two)
//   ADDR_W  8    word-index width, = $clog2(DEPTH)
// PORTS
//   clk                    in   1   clock, all state updates on rising edge
//   rst                    in   1   synchronous, active-high reset
//   istall                 in   1   hold both pipeline registers
//   iflush                 in   1   turn the incoming EX/MEM entry into a bubble
//   iSig_MemRead           in   1   load
//   iSig_MemWrite          in   1   store
//   iSig_Branch            in   1   beq in flight
//   iSig_RegWrite          in   1   passed to WB
//   iSig_MemtoReg          in   1   passed to WB
//   iadder_branch_result   in   32  branch target from Execute
//   iALU_zero              in   1   ALU zero flag from Execute
//   iALU_result            in   32  ALU result / byte address
//   iregfile_read_2        in   32  store data
//   ireg_write_reg         in   5   destination register
//   oPCSrc                 out  1   take branch (to IF)
//   obranch_target         out  32  branch target (to IF)
//   oSig_RegWrite          out  1   MEM/WB RegWrite
//   oSig_MemtoReg          out  1   MEM/WB MemtoReg
//   omem_read_data         out  32  MEM/WB load data
//   oALU_result            out  32  MEM/WB ALU result
//   oreg_write_reg         out  5   MEM/WB destination
//   omisaligned            out  1   misaligned access flag (ALIGN_CHECK_EN only)
// BEHAVIOUR
// - Reset (rst high at an edge): every EX/MEM and MEM/WB field is set to 0, so
//   every output is 0 the cycle after. Memory contents are not changed.
//   Sim init is all-zero. Reset beats stall and flush. A store that is pending
//   in EX/MEM at the reset edge is dropped.
// - EX/MEM register: loads all inputs at each edge while ~istall.
//   - iflush & ~istall: loads data fields but forces MemRead, MemWrite,
//     Branch and RegWrite to 0.
//   - istall & iflush: stall wins and the register holds.
// - Branch: combinational from EX/MEM. oPCSrc = Branch & zero;
//   obranch_target = the registered target. Inputs captured at edge N drive
//   oPCSrc after edge N (1-cycle latency).
// - Address: word index = ALU_result[ADDR_W+1:2]. Upper bits are ignored, so
//   the address wraps modulo DEPTH words.
// - Store: memory written at the edge where EX/MEM.MemWrite & ~istall.
//   Exactly one write per store, even across a stall.
// - Load: synchronous read at the same edge. Data appears on omem_read_data
//   after edge N+1 for inputs captured at edge N. When MemRead is 0,
//   omem_read_data = 0.
// - MEM/WB register: loads RegWrite, MemtoReg, ALU result, destination and
//   read data at each edge while ~istall; holds otherwise.
// - MemRead & MemWrite both set: the store happens and omem_read_data = 0.
// CONFIGURATION
// - `define ALIGN_CHECK_EN:
//   - A MemRead/MemWrite with ALU_result[1:0] != 0 suppresses the write,
//     clears RegWrite in MEM/WB and sets omisaligned.
//   - omisaligned follows the same MEM/WB timing and resets to 0.
// - Without it: address bits [1:0] are ignored, omisaligned is tied to 0, and
//   no extra logic is built.
// STRUCTURE
// - Package mips_pkg: WORD_W=32, REG_W=5, and the EX/MEM and MEM/WB
//   control-bundle typedefs.
// - Sub-module data_mem: single-port RAM, DEPTH x 32, synchronous read,
//   write-enable input. Instantiated once.
// - Pipeline registers and branch logic live in memory_stage.
// TESTING
// 1. rst=1 for 2 cycles, then inputs nonzero with rst held -> all outputs 0
//    and memory unchanged.
// 2. Store 0xDEADBEEF to address 0x10, then load 0x10 -> omem_read_data =
//    0xDEADBEEF two edges after the load is presented, and oSig_MemtoReg = 1.
// 3. Branch=1, zero=1, target 0x40 -> oPCSrc=1 and obranch_target=0x40 after
//    1 edge. zero=0 -> oPCSrc=0.
// 4. Store 0x1 to 0x20 with istall high for 3 cycles -> one write, outputs
//    frozen while stalled. Store with iflush -> memory word unchanged.
// 5. Store to 0x400 (DEPTH=256) -> word 0 written (wrap).
// 6. ALIGN_CHECK_EN: load from 0x13 -> omisaligned=1, oSig_RegWrite=0. Store
//    to 0x13 leaves the word unchanged. Without the macro, the load returns
//    word 0x10.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and pipeline-register bundles for the MIPS MEM stage.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic mem_to_reg;
    } exmem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } memwb_ctrl_t;

    typedef struct packed {
        exmem_ctrl_t              ctrl;
        logic                     zero;
        logic [WORD_W-1:0]        target;
        logic [WORD_W-1:0]        alu;
        logic [WORD_W-1:0]        wdata;
        logic [REG_W-1:0]         wreg;
    } exmem_t;

    typedef struct packed {
        memwb_ctrl_t              ctrl;
        logic [WORD_W-1:0]        alu;
        logic [REG_W-1:0]         wreg;
    } memwb_t;

endpackage

// File: rtl/data_mem.sv
// Single-port DEPTH x 32 data RAM with synchronous read. The registered read
// word doubles as the MEM/WB read-data field, so it honours en (stall) and rst.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = '0;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata_q <= '0;
        else if (en) rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: EX/MEM register, branch resolve, data memory, MEM/WB register.
// Optional ALIGN_CHECK_EN flags and suppresses word-misaligned accesses.
module memory_stage
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              istall,
    input  logic              iflush,
    input  logic              iSig_MemRead,
    input  logic              iSig_MemWrite,
    input  logic              iSig_Branch,
    input  logic              iSig_RegWrite,
    input  logic              iSig_MemtoReg,
    input  logic [WORD_W-1:0] iadder_branch_result,
    input  logic              iALU_zero,
    input  logic [WORD_W-1:0] iALU_result,
    input  logic [WORD_W-1:0] iregfile_read_2,
    input  logic [REG_W-1:0]  ireg_write_reg,
    output logic              oPCSrc,
    output logic [WORD_W-1:0] obranch_target,
    output logic              oSig_RegWrite,
    output logic              oSig_MemtoReg,
    output logic [WORD_W-1:0] omem_read_data,
    output logic [WORD_W-1:0] oALU_result,
    output logic [REG_W-1:0]  oreg_write_reg,
    output logic              omisaligned
);

    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    logic   misaligned;
    logic   mem_we, mem_re;

    always_comb begin
        exmem_d                 = '0;
        exmem_d.ctrl.mem_read   = iSig_MemRead  & ~iflush;
        exmem_d.ctrl.mem_write  = iSig_MemWrite & ~iflush;
        exmem_d.ctrl.branch     = iSig_Branch   & ~iflush;
        exmem_d.ctrl.reg_write  = iSig_RegWrite & ~iflush;
        exmem_d.ctrl.mem_to_reg = iSig_MemtoReg;
        exmem_d.zero            = iALU_zero;
        exmem_d.target          = iadder_branch_result;
        exmem_d.alu             = iALU_result;
        exmem_d.wdata           = iregfile_read_2;
        exmem_d.wreg            = ireg_write_reg;
    end

    always_ff @(posedge clk) begin
        if (rst)          exmem_q <= '0;
        else if (!istall) exmem_q <= exmem_d;
    end

`ifdef ALIGN_CHECK_EN
    logic misaligned_d, misaligned_q;

    always_comb begin
        misaligned_d = (exmem_q.ctrl.mem_read | exmem_q.ctrl.mem_write) &
                       (|exmem_q.alu[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst)          misaligned_q <= 1'b0;
        else if (!istall) misaligned_q <= misaligned_d;
    end

    assign misaligned  = misaligned_d;
    assign omisaligned = misaligned_q;
`else
    assign misaligned  = 1'b0;
    assign omisaligned = 1'b0;
`endif

    // Write only on the edge the entry leaves EX/MEM, so a stalled store lands once;
    // a store still pending at a reset edge is dropped.
    assign mem_we = exmem_q.ctrl.mem_write & ~istall & ~rst & ~misaligned;
    assign mem_re = exmem_q.ctrl.mem_read & ~exmem_q.ctrl.mem_write;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .en    (~istall),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (exmem_q.alu[ADDR_W+1:2]),
        .wdata (exmem_q.wdata),
        .rdata (omem_read_data)
    );

    always_comb begin
        memwb_d                 = '0;
        memwb_d.ctrl.reg_write  = exmem_q.ctrl.reg_write & ~misaligned;
        memwb_d.ctrl.mem_to_reg = exmem_q.ctrl.mem_to_reg;
        memwb_d.alu             = exmem_q.alu;
        memwb_d.wreg            = exmem_q.wreg;
    end

    always_ff @(posedge clk) begin
        if (rst)          memwb_q <= '0;
        else if (!istall) memwb_q <= memwb_d;
    end

    assign oPCSrc         = exmem_q.ctrl.branch & exmem_q.zero;
    assign obranch_target = exmem_q.target;
    assign oSig_RegWrite  = memwb_q.ctrl.reg_write;
    assign oSig_MemtoReg  = memwb_q.ctrl.mem_to_reg;
    assign oALU_result    = memwb_q.alu;
    assign oreg_write_reg = memwb_q.wreg;

endmodule
